keypad_time_entry: RTL
======================

Name: keypad_time_entry

Overview:
- Keypad-side writer for the mm:ss countdown chain built from mod-10/mod-6 BCD digit counters.
- Collects BCD keypresses into a 4-digit entry register, validates the seconds field, then issues a one-cycle active-low load of the timer digits.
- Drives the countdown enable through run/pause, and returns to idle on timer zero or on a CLEAR key.
- Sits between the keypad scanner and the timer digit counters.

Parameters:
- MAX_DIGITS, 4, number of BCD digits held (min_tens, min_ones, sec_tens, sec_ones).
- SEC_TENS_MAX, 5, largest legal sec_tens value at START.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous active-high reset.
- key_valid  in  1  one-cycle strobe; key_code is valid in that cycle.
- key_code  in  4  0-9 digit; 4'hA CLEAR; 4'hB START/PAUSE; 4'hC-4'hF ignored.
- timer_zero  in  1  level from the timer chain: all digits zero.
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  entry register, wired to the timer data inputs.
- loadn  out  1  active-low timer load, one cycle wide.
- en  out  1  countdown enable to the timer chain.
- ndigits  out  3  digits entered so far, 0..4.
- err  out  1  one-cycle pulse: START rejected.
- abort  out  1  one-cycle pulse: run cancelled by CLEAR.

Behaviour:
- Reset: clr=1 at a clock edge forces IDLE, all digits 0, ndigits=0, loadn=1, en=0, err=0, abort=0. clr overrides every other input, including mid-LOAD; loadn is high in the cycle after reset.
- All outputs are registered. A key accepted at edge N is reflected at edge N+1.
- States: IDLE, ENTRY, LOAD, RUN, PAUSE. The encoding lives in the package.
- IDLE, digit key: d0 <= key, ndigits <= 1, go to ENTRY.
- IDLE, CLEAR or START: no effect.
- ENTRY, digit key with ndigits<4: shift left one digit (min_tens<=min_ones<=sec_tens<=sec_ones<=key), ndigits++.
- ENTRY, digit key with ndigits==4: ignored, registers unchanged.
- ENTRY, CLEAR: digits 0, ndigits 0, go to IDLE. abort is not pulsed.
- ENTRY, START with sec_tens<=SEC_TENS_MAX and digits not all zero: go to LOAD.
- ENTRY, START with sec_tens>SEC_TENS_MAX or all digits zero: err=1 for one cycle, stay in ENTRY, digits kept.
- LOAD: loadn=0 for exactly one cycle, en=0, all keys ignored. Next state is RUN.
- RUN: en=1.
  - timer_zero=1: go to IDLE, en=0, digits and ndigits cleared.
  - START: go to PAUSE.
  - CLEAR: abort=1 for one cycle, go to IDLE, cleared.
  - Digit keys are ignored.
- timer_zero is ignored in the first RUN cycle after LOAD, so the previous timer value cannot cause a false finish.
- PAUSE: en=0.
  - START: go to RUN.
  - CLEAR: abort pulse, go to IDLE.
  - timer_zero is ignored.
- Simultaneous key_valid and timer_zero in RUN: timer_zero wins and the key is dropped.
- Digit registers are 4 bits and never wrap. Only values 0-9 are ever written.

Decomposition:
- Package keypad_pkg holds:
  - the state enum;
  - key constants KEY_CLEAR=4'hA and KEY_START=4'hB;
  - function is_digit(key_code) (key <= 9).
- One natural sub-module: bcd_entry_shift. It holds the 4-digit shift register and ndigits counter, with ports clk, clr, shift, clear_all, din, digits, ndigits. The FSM remains in the top module.

Test Plan:
- Reset: clr=1 for 3 cycles with keys active -> all digits 0, ndigits=0, loadn=1, en=0 throughout.
- Entry and load: keys 1,2,3 then START -> digits 0,1,2,3 (01:23) and ndigits=3. loadn=0 for exactly one cycle, 1 cycle after START. en=1 from the following cycle.
- Overflow and invalid seconds: keys 9,9,9,9,9 -> ndigits=4, digits 9,9,9,9 (the fifth key is dropped). START -> err pulse, no loadn, state stays ENTRY.
- Pause, resume and finish: load 00:05, START in RUN -> en=0. START again -> en=1. Drive timer_zero=1 -> next cycle en=0, digits 0, IDLE.
- Abort: CLEAR during RUN -> abort for one cycle, en=0, digits cleared. CLEAR during ENTRY -> digits cleared with abort=0.
- Collisions: key 5 together with timer_zero in RUN -> IDLE, digits 0, key dropped. clr asserted in the LOAD cycle -> next cycle loadn=1, en=0.

Source files
------------

// File: rtl/keypad_time_entry_pkg.sv
// keypad_pkg: shared definitions for the keypad time-entry block.
// Contents: controller state encoding, special key codes, default sizing
// constants and the is_digit() helper used to classify key codes.
package keypad_pkg;

    // Default sizing: four BCD digits (mm:ss), sec_tens limited to 0..5.
    localparam int MAX_DIGITS_DEF   = 4;
    localparam int SEC_TENS_MAX_DEF = 5;

    // Special keys; codes 4'hC..4'hF have no function.
    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_START = 4'hB;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_PAUSE = 3'd4
    } state_t;

    function automatic logic is_digit(input logic [3:0] key_code);
        return (key_code <= 4'd9);
    endfunction

endpackage

// File: rtl/keypad_time_entry_if.sv
// keypad_time_entry_if: bundles the keypad-scanner inputs, the timer
// feedback and everything the block drives toward the timer digit chain.
//   key_valid/key_code : one-cycle key strobe and its code
//   timer_zero         : level from the timer chain, all digits zero
//   min_tens..sec_ones : entry register, wired to the timer data inputs
//   loadn              : active-low one-cycle timer load
//   en                 : countdown enable
//   ndigits            : digits entered so far (0..4)
//   err / abort        : one-cycle pulses (START rejected / run cancelled)
// modport master: the keypad/timer side; modport slave: keypad_time_entry.
interface keypad_time_entry_if;

    logic       key_valid;
    logic [3:0] key_code;
    logic       timer_zero;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       loadn;
    logic       en;
    logic [2:0] ndigits;
    logic       err;
    logic       abort;

    modport master (
        output key_valid, key_code, timer_zero,
        input  min_tens, min_ones, sec_tens, sec_ones,
        input  loadn, en, ndigits, err, abort
    );

    modport slave (
        input  key_valid, key_code, timer_zero,
        output min_tens, min_ones, sec_tens, sec_ones,
        output loadn, en, ndigits, err, abort
    );

endinterface

// File: rtl/keypad_time_entry_shift.sv
// bcd_entry_shift: BCD digit shift register plus digit counter.
// Ports:
//   clk, clr  : clock and synchronous active-high reset
//   shift     : shift din in at the low digit (dropped once full)
//   clear_all : zero all digits and the count; combined with shift the
//               register restarts holding only din
//   din       : BCD digit to shift in
//   digits    : digits[MAX_DIGITS-1] is the oldest (min_tens), digits[0]
//               the newest (sec_ones)
//   ndigits   : number of digits entered, 0..MAX_DIGITS
module bcd_entry_shift #(
    parameter int MAX_DIGITS = 4
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic                        shift,
    input  logic                        clear_all,
    input  logic [3:0]                  din,
    output logic [MAX_DIGITS-1:0][3:0]  digits,
    output logic [2:0]                  ndigits
);

    localparam logic [2:0] FULL_COUNT = 3'(MAX_DIGITS);

    // clear_all takes priority so a fresh entry always starts from zeros;
    // once the register is full further digits are ignored, never wrapped.
    always_ff @(posedge clk) begin
        if (clr) begin
            digits  <= '0;
            ndigits <= 3'd0;
        end else if (clear_all) begin
            digits <= '0;
            if (shift) begin
                digits[0] <= din;
                ndigits   <= 3'd1;
            end else begin
                ndigits <= 3'd0;
            end
        end else if (shift && (ndigits < FULL_COUNT)) begin
            digits  <= {digits[MAX_DIGITS-2:0], din};
            ndigits <= ndigits + 3'd1;
        end
    end

endmodule

// File: rtl/keypad_time_entry.sv
// keypad_time_entry: keypad-side writer for the mm:ss countdown chain.
// Collects BCD keys into a 4-digit entry register, validates it on START,
// pulses loadn for one cycle to load the timer, then runs/pauses the
// countdown until timer_zero or CLEAR returns it to idle.
// Ports:
//   clk : system clock, rising edge
//   clr : synchronous active-high reset, overrides everything
//   bus : keypad_time_entry_if.slave (key strobe, timer_zero, digit
//         outputs, loadn, en, ndigits, err, abort); all outputs registered
module keypad_time_entry
    import keypad_pkg::*;
#(
    parameter int MAX_DIGITS   = MAX_DIGITS_DEF,
    parameter int SEC_TENS_MAX = SEC_TENS_MAX_DEF
) (
    input  logic                 clk,
    input  logic                 clr,
    keypad_time_entry_if.slave   bus
);

    localparam logic [3:0] SEC_TENS_LIMIT = 4'(SEC_TENS_MAX);

    state_t state;
    state_t next_state;

    logic                       shift;
    logic                       clear_all;
    logic                       err_next;
    logic                       abort_next;
    logic                       first_run;
    logic                       loadn_q;
    logic                       en_q;
    logic                       err_q;
    logic                       abort_q;
    logic [MAX_DIGITS-1:0][3:0] digits;
    logic [2:0]                 ndigits;

    logic key_digit;
    logic key_clear;
    logic key_start;
    logic entry_ok;
    logic zero_seen;

    bcd_entry_shift #(
        .MAX_DIGITS (MAX_DIGITS)
    ) u_shift (
        .clk       (clk),
        .clr       (clr),
        .shift     (shift),
        .clear_all (clear_all),
        .din       (bus.key_code),
        .digits    (digits),
        .ndigits   (ndigits)
    );

    assign key_digit = bus.key_valid && is_digit(bus.key_code);
    assign key_clear = bus.key_valid && (bus.key_code == KEY_CLEAR);
    assign key_start = bus.key_valid && (bus.key_code == KEY_START);

    // digits[1] is sec_tens; an all-zero entry would finish instantly.
    assign entry_ok  = (digits[1] <= SEC_TENS_LIMIT) && (digits != '0);

    // The timer still shows its previous (possibly zero) value during the
    // first RUN cycle after a load, so timer_zero is masked there.
    assign zero_seen = bus.timer_zero && !first_run;

    // Next-state and one-cycle control decode.
    always_comb begin
        next_state = state;
        shift      = 1'b0;
        clear_all  = 1'b0;
        err_next   = 1'b0;
        abort_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (key_digit) begin
                    shift      = 1'b1;
                    clear_all  = 1'b1;
                    next_state = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (key_digit) begin
                    shift = 1'b1;
                end else if (key_clear) begin
                    clear_all  = 1'b1;
                    next_state = ST_IDLE;
                end else if (key_start) begin
                    if (entry_ok) begin
                        next_state = ST_LOAD;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                next_state = ST_RUN;
            end
            ST_RUN: begin
                // timer_zero outranks any key arriving in the same cycle.
                if (zero_seen) begin
                    clear_all  = 1'b1;
                    next_state = ST_IDLE;
                end else if (key_start) begin
                    next_state = ST_PAUSE;
                end else if (key_clear) begin
                    abort_next = 1'b1;
                    clear_all  = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            ST_PAUSE: begin
                if (key_start) begin
                    next_state = ST_RUN;
                end else if (key_clear) begin
                    abort_next = 1'b1;
                    clear_all  = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: begin
                clear_all  = 1'b1;
                next_state = ST_IDLE;
            end
        endcase
    end

    // State register; loadn and en are registered from next_state so they
    // line up exactly with the LOAD and RUN states.
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= ST_IDLE;
            first_run <= 1'b0;
            loadn_q   <= 1'b1;
            en_q      <= 1'b0;
            err_q     <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state     <= next_state;
            first_run <= (state == ST_LOAD);
            loadn_q   <= (next_state != ST_LOAD);
            en_q      <= (next_state == ST_RUN);
            err_q     <= err_next;
            abort_q   <= abort_next;
        end
    end

    assign bus.min_tens = digits[3];
    assign bus.min_ones = digits[2];
    assign bus.sec_tens = digits[1];
    assign bus.sec_ones = digits[0];
    assign bus.ndigits  = ndigits;
    assign bus.loadn    = loadn_q;
    assign bus.en       = en_q;
    assign bus.err      = err_q;
    assign bus.abort    = abort_q;

endmodule
